// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiplier (multiplicador_param).
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Step counter width for a given operand width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage : mul_pkg

// File: rtl/mul_counter.sv
// Step counter for the multiplier: cleared on accept, advanced once per CALC cycle.
module mul_counter
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last_c
);

  localparam int unsigned CW = cnt_w(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // High while the step that completes the product is being taken.
  assign last_c = (cnt == CW'(WIDTH - 1));

endmodule : mul_counter

// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier, one partial product per clock, start/busy/done handshake.
// Optional two's-complement mode when MUL_SIGNED_EN is defined (adds the signed_op port).
module multiplicador_param
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mndo,
  input  logic [WIDTH-1:0]   mdor,
`ifdef MUL_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] produto
);

  localparam int unsigned PW = 2 * WIDTH;

  mul_state_t state, state_nxt;
  logic       busy_d, done_d;
  logic       accept, last_c;

  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH:0]   hi, addend;
  logic [PW-1:0]    acc_step;

`ifdef MUL_SIGNED_EN
  logic sop;
`endif

  assign accept = (state == IDLE) && start;

  mul_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .inc    (state == CALC),
    .last_c (last_c)
  );

  // State register with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = CALC;
      CALC:    if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are decoded from the upcoming state so they line up with it.
  always_comb begin
    busy_d = (state_nxt != IDLE);
    done_d = (state_nxt == DONE);
  end

  // One shift-add step; the WIDTH+1 bit sum keeps the carry, which lands in the top bit.
  always_comb begin
    hi     = {1'b0, acc[PW-1:WIDTH]};
    addend = {1'b0, mcand};
`ifdef MUL_SIGNED_EN
    if (sop) begin
      hi     = {acc[PW-1], acc[PW-1:WIDTH]};
      addend = {mcand[WIDTH-1], mcand};
    end
    if (acc[0]) begin
      // The multiplier's sign bit carries negative weight, so its step subtracts.
      if (sop && last_c) hi = hi - addend;
      else               hi = hi + addend;
    end
`else
    if (acc[0]) hi = hi + addend;
`endif
    acc_step = {hi, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      acc   <= '0;
`ifdef MUL_SIGNED_EN
      sop   <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= mndo;
      acc   <= {{WIDTH{1'b0}}, mdor};
`ifdef MUL_SIGNED_EN
      sop   <= signed_op;
`endif
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

  assign produto = acc;

endmodule : multiplicador_param

// File: tb/tb_multiplicador_param.sv
// Self-checking bench for multiplicador_param: directed cases plus random ops vs an arithmetic model.
module tb_multiplicador_param;

  localparam int unsigned W  = 16;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  mndo = '0;
  logic [W-1:0]  mdor = '0;
  logic          signed_op = 1'b0;
  logic          busy, done;
  logic [PW-1:0] produto;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multiplicador_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mndo      (mndo),
    .mdor      (mdor),
`ifdef MUL_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .produto   (produto)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact product, with operands extended according to the requested interpretation.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [PW-1:0] xa, xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  // Called at the negedge just after the accepting edge; returns the cycle index of done.
  task automatic wait_done(output int cyc);
    int n;
    n = 0;
    while (!done && n < int'(W) + 8) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
    cyc = n + 1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [PW-1:0] exp);
    int cyc;
    @(negedge clk);
    mndo = a; mdor = b; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mndo = W'($urandom); mdor = W'($urandom); signed_op = ~s;
    check({tag, "_busy_calc"}, 64'(busy), 64'(1));
    wait_done(cyc);
    check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    check({tag, "_busy_done"}, 64'(busy), 64'(1));
    check(tag, 64'(produto), 64'(exp));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_busy_after"}, 64'(busy), 64'(0));
    check({tag, "_held"}, 64'(produto), 64'(exp));
  endtask

  initial begin
    int cyc;
    logic [W-1:0] a, b;
    logic s;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_prod", 64'(produto), 64'(0));
    rst = 1'b1;

    run_op("mul_3x5", 16'd3, 16'd5, 1'b0, 32'd15);
    run_op("mul_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run_op("mul_zero", 16'h0000, 16'h1234, 1'b0, 32'd0);
    run_op("mul_one", 16'h0001, 16'hFFFF, 1'b0, 32'h0000_FFFF);

    // Start held through CALC/DONE is ignored; accepted in the following IDLE cycle.
    @(negedge clk);
    mndo = 16'd100; mdor = 16'd200; start = 1'b1;
    @(negedge clk);
    mndo = 16'd77; mdor = 16'd88;
    wait_done(cyc);
    check("held_latency", 64'(cyc), 64'(W + 1));
    check("held_first", 64'(produto), 64'(32'd20000));
    @(negedge clk);
    check("held_idle_busy", 64'(busy), 64'(0));
    check("held_idle_prod", 64'(produto), 64'(32'd20000));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'(1));
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'(W + 1));
    check("b2b_second", 64'(produto), 64'(32'd6776));

    // Reset in the middle of a calculation.
    @(negedge clk);
    mndo = 16'h1234; mdor = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_prod", 64'(produto), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 16'd7, 16'd9, 1'b0, 32'd63);

`ifdef MUL_SIGNED_EN
    run_op("s_m3x5", 16'hFFFD, 16'd5, 1'b1, 32'hFFFF_FFF1);
    run_op("s_min_min", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    run_op("s_m1_m1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
    run_op("u_min_min", 16'h8000, 16'h8000, 1'b0, 32'h4000_0000);
    run_op("u_m1_m1", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
`endif

    // Random operands against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 10 == 0) a = '0;
      if (i % 10 == 1) b = {W{1'b1}};
`ifdef MUL_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_op("rand", a, b, s, model(a, b, s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_multiplicador_param
